// File: rtl/serial_frame_rx_pkg.sv
// Shared types and helpers for the serial frame receiver.
// Holds the receiver FSM state enum and an even-parity helper.
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam int unsigned PAR_MAX_W = 16;

  function automatic logic even_parity(
    input logic [PAR_MAX_W-1:0] v
  );
    return ^v;
  endfunction

endpackage

// File: rtl/sfr_shift.sv
// WIDTH-bit serial-in shift register for the frame receiver.
// Ports: clk, rst (async, low), shift_en_i, bit_i -> data_o.
module sfr_shift #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // MSB-first: the first bit walks up to the top.
  // LSB-first: the first bit walks down to bit 0.
  always_comb begin
    sr_d = sr_q;
    if (shift_en_i) begin
      if (MSB_FIRST != 0) begin
        sr_d = {sr_q[WIDTH-2:0], bit_i};
      end else begin
        sr_d = {bit_i, sr_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign data_o = sr_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start, WIDTH data, opt. parity, stop.
// Ports: clk, rst, data_in, out_ready, err_clr -> data_out,
//        out_valid, frame_err, parity_err, overrun.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic PEN = (PARITY_EN != 0);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             shift_en, par_smp, stop_smp;
  logic             last_bit;
  logic [WIDTH-1:0] shift_data;

  logic             par_bit_q;
  logic             done_q, stop_bad_q, par_bad_q;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, parity_err_q;
  logic             overrun_q, overrun_d;
  logic             good, can_load, ovr_evt;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (data_in) state_d = S_DATA;
      S_DATA:   if (last_bit) state_d = PEN ? S_PARITY : S_STOP;
      S_PARITY: state_d = S_STOP;
      S_STOP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shift_en = (state_q == S_DATA);
    par_smp  = (state_q == S_PARITY);
    stop_smp = (state_q == S_STOP);
    cnt_d    = '0;
    if (shift_en && !last_bit) cnt_d = cnt_q + CW'(1);
  end

  sfr_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en),
    .bit_i      (data_in),
    .data_o     (shift_data)
  );

  // Verdict is registered at the stop sample and acted on one
  // edge later; the shifter is not touched again until a new
  // frame's first data bit, so back-to-back frames are safe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bit_q  <= 1'b0;
      done_q     <= 1'b0;
      stop_bad_q <= 1'b0;
      par_bad_q  <= 1'b0;
    end else begin
      if (par_smp) par_bit_q <= data_in;
      done_q     <= stop_smp;
      stop_bad_q <= stop_smp & data_in;
      par_bad_q  <= stop_smp & PEN &
        (even_parity(PAR_MAX_W'(shift_data)) ^ par_bit_q);
    end
  end

  assign good     = done_q & ~stop_bad_q & ~par_bad_q;
  assign can_load = ~out_valid_q | out_ready;
  assign ovr_evt  = good & ~can_load;

  always_comb begin
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    if (good && can_load) begin
      data_out_d  = shift_data;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    overrun_d = ovr_evt | (overrun_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= done_q & stop_bad_q;
      parity_err_q <= done_q & ~stop_bad_q & par_bad_q;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: three instances
// (MSB-first, LSB-first, MSB-first with parity).
module tb_serial_frame_rx;

  localparam int K_DATA = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] din;
  logic [2:0] rdy;
  logic [2:0] clr;
  logic [7:0] dout [3];
  logic [2:0] valid;
  logic [2:0] ferr;
  logic [2:0] perr;
  logic [2:0] ovr;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  serial_frame_rx #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0)) u_a (
    .clk(clk), .rst(rst), .data_in(din[0]), .out_ready(rdy[0]),
    .err_clr(clr[0]), .data_out(dout[0]), .out_valid(valid[0]),
    .frame_err(ferr[0]), .parity_err(perr[0]), .overrun(ovr[0])
  );

  serial_frame_rx #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) u_b (
    .clk(clk), .rst(rst), .data_in(din[1]), .out_ready(rdy[1]),
    .err_clr(clr[1]), .data_out(dout[1]), .out_valid(valid[1]),
    .frame_err(ferr[1]), .parity_err(perr[1]), .overrun(ovr[1])
  );

  serial_frame_rx #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) u_c (
    .clk(clk), .rst(rst), .data_in(din[2]), .out_ready(rdy[2]),
    .err_clr(clr[2]), .data_out(dout[2]), .out_valid(valid[2]),
    .frame_err(ferr[2]), .parity_err(perr[2]), .overrun(ovr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input int k, input int kind,
                      input logic [7:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_cmp(input int k, input int kind,
                         input logic [7:0] d);
    exp_t e;
    bit   have;
    have = 0;
    e.kind = -1;
    e.data = '0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
      default:
        if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL sb inst%0d unexpected kind %0d data %h",
               k, kind, d);
    end else if (e.kind != kind ||
                 (kind == K_DATA && e.data !== d)) begin
      errors++;
      $display("FAIL sb inst%0d got kind %0d data %h expected kind %0d data %h",
               k, kind, d, e.kind, e.data);
    end
  endtask

  // Monitor: sample between the drive edge and the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        if (ferr[k]) pop_cmp(k, K_FERR, 8'h00);
        if (perr[k]) pop_cmp(k, K_PERR, 8'h00);
        if (valid[k] && rdy[k]) pop_cmp(k, K_DATA, dout[k]);
      end
    end
  end

  task automatic send(input int k, input logic [7:0] s,
                      input logic par, input logic stp,
                      input bit use_par);
    @(negedge clk) din[k] = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk) din[k] = s[i];
    end
    if (use_par) begin
      @(negedge clk) din[k] = par;
    end
    @(negedge clk) din[k] = stp;
  endtask

  task automatic idle(input int k);
    @(negedge clk) din[k] = 1'b0;
  endtask

  task automatic take(input int k);
    repeat (2) @(negedge clk);
    rdy[k] = 1'b1;
    @(negedge clk) rdy[k] = 1'b0;
  endtask

  task automatic clr_pulse(input int k);
    @(negedge clk) clr[k] = 1'b1;
    @(negedge clk) clr[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    din = '0;
    rdy = '0;
    clr = '0;
    repeat (3) @(negedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset outs inst%0d", k),
          {16'h0, dout[k], 3'b0, valid[k], ferr[k], perr[k], ovr[k], 1'b0},
          32'h0);
    end
    @(negedge clk) rst = 1'b1;

    // MSB-first 0xA5, latency from start sample.
    push(0, K_DATA, 8'hA5);
    send(0, 8'hA5, 1'b0, 1'b0, 0);
    idle(0);
    #2 chk("A5 valid before latency", valid[0], 0);
    @(negedge clk);
    #2 chk("A5 valid at latency", valid[0], 1);
    chk("A5 data", dout[0], 8'hA5);
    @(negedge clk) rdy[0] = 1'b1;
    @(negedge clk) rdy[0] = 1'b0;
    #2 chk("A5 valid cleared", valid[0], 0);

    // LSB-first: same stream, then back-to-back with ready high.
    rdy[1] = 1'b1;
    push(1, K_DATA, 8'hA5);
    send(1, 8'hA5, 1'b0, 1'b0, 0);
    push(1, K_DATA, 8'hC8);
    send(1, 8'h13, 1'b0, 1'b0, 0);
    push(1, K_DATA, 8'hF0);
    send(1, 8'h0F, 1'b0, 1'b0, 0);
    idle(1);
    repeat (3) @(negedge clk);
    rdy[1] = 1'b0;

    // Parity: bad parity dropped, good parity accepted.
    push(2, K_PERR, 8'h00);
    send(2, 8'h03, 1'b1, 1'b0, 1);
    idle(2);
    repeat (3) @(negedge clk);
    #2 chk("perr no valid", valid[2], 0);
    push(2, K_DATA, 8'h03);
    send(2, 8'h03, 1'b0, 1'b0, 1);
    idle(2);
    take(2);

    // Overrun, clear, and clear coinciding with a new overrun.
    push(0, K_DATA, 8'h11);
    send(0, 8'h11, 1'b0, 1'b0, 0);
    idle(0);
    send(0, 8'h22, 1'b0, 1'b0, 0);
    idle(0);
    @(negedge clk);
    #2 chk("ovr set", ovr[0], 1);
    chk("ovr data kept", dout[0], 8'h11);
    chk("ovr valid kept", valid[0], 1);
    clr_pulse(0);
    #2 chk("ovr cleared", ovr[0], 0);
    send(0, 8'h33, 1'b0, 1'b0, 0);
    @(negedge clk);
    din[0] = 1'b0;
    clr[0] = 1'b1;
    @(negedge clk) clr[0] = 1'b0;
    #2 chk("ovr clr collide", ovr[0], 1);
    chk("ovr collide data", dout[0], 8'h11);
    clr_pulse(0);
    #2 chk("ovr cleared 2", ovr[0], 0);
    take(0);

    // Bad stop bit, then an immediate start on the next cycle.
    push(0, K_FERR, 8'h00);
    send(0, 8'h5A, 1'b0, 1'b1, 0);
    push(0, K_DATA, 8'h3C);
    send(0, 8'h3C, 1'b0, 1'b0, 0);
    idle(0);
    take(0);

    // Reset mid-frame, then a full 0xFF frame.
    @(negedge clk) din[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) din[0] = i[0];
    end
    @(negedge clk);
    rst = 1'b0;
    din[0] = 1'b0;
    #2 chk("midrst outs",
           {dout[0], valid[0], ferr[0], perr[0], ovr[0]}, 0);
    @(negedge clk) rst = 1'b1;
    push(0, K_DATA, 8'hFF);
    send(0, 8'hFF, 1'b0, 1'b0, 0);
    idle(0);
    take(0);

    repeat (5) @(negedge clk);
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    chk("q2 drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per frame (legal range 2..16).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 means the first data bit received is data_out[WIDTH-1], 0 means it is data_out[0].
REQ-003 SHALL have parameter PARITY_EN, default 0; 1 means one even-parity bit follows the data bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port data_in, input, 1 bit: serial line, sampled once per clk, idle low.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer accepts data_out when high together with out_valid.
REQ-008 SHALL have port err_clr, input, 1 bit: synchronous clear of the sticky overrun flag.
REQ-009 SHALL have port data_out, output, WIDTH bits: last accepted frame payload.
REQ-010 SHALL have port out_valid, output, 1 bit: data_out holds an unconsumed frame.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse, bad stop bit.
REQ-012 SHALL have port parity_err, output, 1 bit: one-cycle pulse, parity mismatch (held 0 when PARITY_EN=0).
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag, a good frame was dropped.

Function
REQ-014 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE SHALL go to DATA when data_in=1 is sampled (start bit); otherwise it stays in IDLE.
REQ-016 DATA SHALL shift in one bit per cycle for exactly WIDTH cycles using a bit counter of $clog2(WIDTH) bits, then go to PARITY if PARITY_EN=1, else to STOP.
REQ-017 PARITY SHALL sample one bit; XOR of the WIDTH data bits and the parity bit must be 0; it then goes to STOP.
REQ-018 STOP SHALL expect data_in=0; it always returns to IDLE, and a 1 there is never treated as a new start bit.
REQ-019 A stop bit of 1 SHALL discard the frame and pulse frame_err on the cycle after the stop sample.
REQ-020 On a parity mismatch with a valid stop bit, the block SHALL discard the frame and pulse parity_err on the cycle after the stop sample; if both errors occur, only frame_err pulses.
REQ-021 A good frame SHALL load data_out and set out_valid on the clock edge after the stop-bit sample edge: the start sample to out_valid latency is WIDTH+2+PARITY_EN edges.
REQ-022 out_valid SHALL clear on any cycle where out_valid and out_ready are both 1, unless a new good frame loads on that same cycle, in which case out_valid stays 1 with the new data.
REQ-023 If a good frame completes while out_valid=1 and out_ready=0, the block SHALL drop the new frame, keep data_out unchanged and set overrun.
REQ-024 overrun SHALL remain 1 until err_clr=1 is sampled; if err_clr coincides with a new overrun event, overrun stays set.
REQ-025 data_out SHALL remain stable while out_valid=1 except under REQ-022.
REQ-026 Back-to-back frames SHALL be accepted: a start bit may be sampled on the cycle immediately after STOP.

Reset
REQ-027 While rst=0, the block SHALL asynchronously force state=IDLE, bit counter=0, shift register=0, data_out=0, out_valid=0, frame_err=0, parity_err=0 and overrun=0.
REQ-028 Reset asserted mid-frame SHALL abandon the partial frame with no error pulse and no data_out update.
REQ-029 The first start-bit sample after reset SHALL be on the first rising edge after rst deasserts.

Structure
REQ-030 Package serial_frame_rx_pkg SHALL hold the FSM state enum and a function computing even parity over a vector.
REQ-031 A sub-module sfr_shift SHALL implement the WIDTH-bit shift register with direction selected by MSB_FIRST.
REQ-032 A top-level wrapper mapping io_in[0]=clk, io_in[1]=rst, io_in[2]=data_in and io_out[7:0]=data_out is out of scope for this block.

Verification
REQ-033 WIDTH=8, MSB_FIRST=1: drive start, bits 1,0,1,0,0,1,0,1, stop 0, out_ready=0 -> data_out=0xA5 and out_valid=1 exactly 10 edges after the start sample.
REQ-034 MSB_FIRST=0, same bit stream -> data_out=0xA5 with bit order reversed relative to REQ-033 (first bit received in data_out[0]), out_valid=1.
REQ-035 PARITY_EN=1: send 0x03 with parity 1 -> parity_err pulses for 1 cycle, out_valid stays 0; resend with parity 0 -> data_out=0x03.
REQ-036 Send 0x11 with out_ready=0, then 0x22 -> data_out stays 0x11 and overrun=1; err_clr=1 for one cycle -> overrun=0.
REQ-037 Send 0x5A with stop bit 1 -> frame_err pulses for 1 cycle, state returns to IDLE, and a following good frame 0x3C is received.
REQ-038 Assert rst after 4 data bits -> all outputs 0 and no error pulse; a following full frame 0xFF is received correctly.
